// File: rtl/udm_gpio_pkg.sv
// Shared constants and helpers for the UDM GPIO register block.
package udm_gpio_pkg;

  // Register byte offsets from the block base address.
  localparam logic [4:0] REG_OUT         = 5'h00;
  localparam logic [4:0] REG_IN          = 5'h04;
  localparam logic [4:0] REG_OUT_SET     = 5'h08;
  localparam logic [4:0] REG_OUT_CLR     = 5'h0C;
  localparam logic [4:0] REG_EDGE_STATUS = 5'h10;
  localparam logic [4:0] REG_EDGE_MASK   = 5'h14;
  localparam logic [4:0] REG_INFO        = 5'h18;
  localparam logic [4:0] REG_RSVD        = 5'h1C;

  // Version byte reported in the top byte of INFO.
  localparam logic [7:0] INFO_VERSION = 8'h01;

  // Expand a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/udm_gpio_sync.sv
// Input synchroniser with one-cycle history and a post-reset arming counter.
module udm_gpio_sync
  import udm_gpio_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_armed
);

  // The chain resets to zero, so the first STAGES+1 cycles can show false edges.
  localparam int unsigned ArmCount = STAGES + 1;

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_arm_cnt;
  logic             w_armed;

  // Flop chain that brings the asynchronous inputs into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_gpio;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Previous synchronised sample for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Arm counter saturates once the chain and history hold real samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 4'd1;
    end
  end

  assign w_armed = (r_arm_cnt == 4'(ArmCount));

  assign o_sync  = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;
  assign o_armed = w_armed;

endmodule

// File: rtl/udm_gpio_regs.sv
// Register-mapped GPIO slave on the UDM memory bus: output register with
// set/clear aliases, synchronised inputs, sticky masked edge status, irq.
module udm_gpio_regs
  import udm_gpio_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 bus_req_i,
  input  logic                 bus_we_i,
  input  logic [31:0]          bus_addr_bi,
  input  logic [3:0]           bus_be_bi,
  input  logic [31:0]          bus_wdata_bi,
  output logic                 bus_ack_o,
  output logic                 bus_resp_o,
  output logic [31:0]          bus_rdata_bo,
  input  logic [IN_WIDTH-1:0]  gpio_bi,
  output logic [OUT_WIDTH-1:0] gpio_bo,
  output logic                 irq_o
);

  localparam logic [31:0] InfoWord = {INFO_VERSION, 8'(SYNC_STAGES), 8'(IN_WIDTH),
                                      8'(OUT_WIDTH)};

  logic [OUT_WIDTH-1:0] r_out;
  logic [IN_WIDTH-1:0]  r_edge_status;
  logic [IN_WIDTH-1:0]  r_edge_mask;
  logic                 r_irq;
  logic                 r_resp;
  logic [31:0]          r_rdata;

  logic                 w_hit;
  logic                 w_wr;
  logic                 w_rd;
  logic [4:0]           w_offs;
  logic [31:0]          w_be_mask;
  logic [OUT_WIDTH-1:0] w_bm_out;
  logic [OUT_WIDTH-1:0] w_wd_out;
  logic [IN_WIDTH-1:0]  w_bm_in;
  logic [IN_WIDTH-1:0]  w_wd_in;
  logic [OUT_WIDTH-1:0] w_out_nxt;
  logic [IN_WIDTH-1:0]  w_mask_nxt;
  logic [IN_WIDTH-1:0]  w_status_nxt;
  logic [31:0]          w_rd_val;
  logic [IN_WIDTH-1:0]  w_sync;
  logic [IN_WIDTH-1:0]  w_rise;
  logic [IN_WIDTH-1:0]  w_fall;
  logic                 w_armed;
  logic                 w_unused_addr;

  udm_gpio_sync #(
    .WIDTH  (IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk_i),
    .i_rst_n (arst_n_i),
    .i_gpio  (gpio_bi),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_armed (w_armed)
  );

  // Always ready: every request is accepted in the cycle it is presented.
  assign bus_ack_o = bus_req_i;

  // Sub-word address bits carry no meaning; registers are word aligned.
  assign w_unused_addr = ^bus_addr_bi[1:0];

  assign w_hit     = (bus_addr_bi[31:5] == ADDR_BASE[31:5]);
  assign w_offs    = {bus_addr_bi[4:2], 2'b00};
  assign w_wr      = bus_req_i & bus_we_i & w_hit;
  assign w_rd      = bus_req_i & ~bus_we_i;
  assign w_be_mask = be_to_mask(bus_be_bi);

  // Bits above the port widths are dropped here, so they never reach state.
  assign w_bm_out = OUT_WIDTH'(w_be_mask);
  assign w_wd_out = OUT_WIDTH'(bus_wdata_bi & w_be_mask);
  assign w_bm_in  = IN_WIDTH'(w_be_mask);
  assign w_wd_in  = IN_WIDTH'(bus_wdata_bi & w_be_mask);

  // Next-state for OUT and EDGE_MASK from byte-masked writes and aliases.
  always_comb begin
    w_out_nxt  = r_out;
    w_mask_nxt = r_edge_mask;
    if (w_wr) begin
      case (w_offs)
        REG_OUT:       w_out_nxt  = (r_out & ~w_bm_out) | w_wd_out;
        REG_OUT_SET:   w_out_nxt  = r_out | w_wd_out;
        REG_OUT_CLR:   w_out_nxt  = r_out & ~w_wd_out;
        REG_EDGE_MASK: w_mask_nxt = (r_edge_mask & ~w_bm_in) | w_wd_in;
        default: ;
      endcase
    end
  end

  // Sticky status: W1C first, then new edges OR in so a same-cycle edge wins.
  always_comb begin
    w_status_nxt = r_edge_status;
    if (w_wr && (w_offs == REG_EDGE_STATUS)) begin
      w_status_nxt = w_status_nxt & ~w_wd_in;
    end
    if (w_armed) begin
      w_status_nxt = w_status_nxt | w_rise | w_fall;
    end
  end

  // Read mux; write-only and reserved offsets return zero.
  always_comb begin
    w_rd_val = '0;
    case (w_offs)
      REG_OUT:         w_rd_val = 32'(r_out);
      REG_IN:          w_rd_val = 32'(w_sync);
      REG_EDGE_STATUS: w_rd_val = 32'(r_edge_status);
      REG_EDGE_MASK:   w_rd_val = 32'(r_edge_mask);
      REG_INFO:        w_rd_val = InfoWord;
      default:         w_rd_val = '0;
    endcase
  end

  // Architectural register state.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_out         <= '0;
      r_edge_mask   <= '0;
      r_edge_status <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_out         <= w_out_nxt;
      r_edge_mask   <= w_mask_nxt;
      r_edge_status <= w_status_nxt;
      r_irq         <= |(r_edge_status & r_edge_mask);
    end
  end

  // One-cycle read response; misses still answer so the bus never stalls.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= (w_rd && w_hit) ? w_rd_val : 32'h0;
    end
  end

  assign gpio_bo      = r_out;
  assign bus_resp_o   = r_resp;
  assign bus_rdata_bo = r_rdata;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_udm_gpio_regs.sv
// Self-checking bench for udm_gpio_regs: directed steps plus a randomised
// phase, all compared against a cycle-level behavioural model.
module tb_udm_gpio_regs;

  localparam int unsigned S    = 2;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] INFO = 32'h01021010;

  logic        clk;
  logic        arst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;
  logic [15:0] gpio;
  logic [15:0] gpio_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [15:0] m_out, m_mask, m_status;
  logic        m_irq, m_resp;
  logic [31:0] m_rdata;
  logic [15:0] hist [0:7];
  int          cyc;

  udm_gpio_regs #(
    .ADDR_BASE   (BASE),
    .OUT_WIDTH   (16),
    .IN_WIDTH    (16),
    .SYNC_STAGES (S)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .bus_req_i    (req),
    .bus_we_i     (we),
    .bus_addr_bi  (addr),
    .bus_be_bi    (be),
    .bus_wdata_bi (wdata),
    .bus_ack_o    (ack),
    .bus_resp_o   (resp),
    .bus_rdata_bo (rdata),
    .gpio_bi      (gpio),
    .gpio_bo      (gpio_out),
    .irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_mask = '0; m_status = '0; m_irq = 1'b0;
    m_resp = 1'b0; m_rdata = '0; cyc = 0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] off, input logic [15:0] in_v);
    case (off)
      5'h00:   return {16'h0, m_out};
      5'h04:   return {16'h0, in_v};
      5'h10:   return {16'h0, m_status};
      5'h14:   return {16'h0, m_mask};
      5'h18:   return INFO;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: predict from this cycle's inputs, then compare outputs.
  task automatic tick();
    logic [15:0] in_v, prev_v, n_out, n_mask, n_status;
    logic [31:0] bm, wd;
    logic [4:0]  off;
    logic        hit, n_irq;
    hist[0] = gpio;
    in_v    = hist[S];
    prev_v  = hist[S+1];
    hit     = (addr[31:5] == BASE[31:5]);
    off     = {addr[4:2], 2'b00};
    bm      = '0;
    for (int b = 0; b < 4; b++) if (be[b]) bm = bm | (32'hFF << (8 * b));
    wd       = wdata & bm;
    n_out    = m_out;
    n_mask   = m_mask;
    n_status = m_status;
    check("ack", {31'h0, ack}, {31'h0, req});
    if (req && !we) begin
      m_resp  = 1'b1;
      m_rdata = hit ? model_read(off, in_v) : 32'h0;
    end else begin
      m_resp  = 1'b0;
      m_rdata = 32'h0;
    end
    if (req && we && hit) begin
      case (off)
        5'h00: n_out    = (m_out & ~bm[15:0]) | wd[15:0];
        5'h08: n_out    = m_out | wd[15:0];
        5'h0C: n_out    = m_out & ~wd[15:0];
        5'h10: n_status = m_status & ~wd[15:0];
        5'h14: n_mask   = (m_mask & ~bm[15:0]) | wd[15:0];
        default: ;
      endcase
    end
    if (cyc >= int'(S) + 1) n_status = n_status | (in_v ^ prev_v);
    n_irq = |(m_status & m_mask);
    @(posedge clk);
    #1;
    m_out = n_out; m_mask = n_mask; m_status = n_status; m_irq = n_irq;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    cyc++;
    check("gpio_bo", {16'h0, gpio_out}, {16'h0, m_out});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("resp", {31'h0, resp}, {31'h0, m_resp});
    check("rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF; wdata = 32'h0;
    tick();
    req = 1'b0;
  endtask

  task automatic do_reset();
    req = 1'b0; we = 1'b0;
    arst_n = 1'b0;
    #2;
    check("rst_gpio_bo", {16'h0, gpio_out}, 32'h0);
    check("rst_resp", {31'h0, resp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    arst_n = 1'b1;
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    arst_n = 1'b1;
    gpio = 16'hA5A5;
    model_reset();
    #3;

    // Reset, synchronised input read, arming suppresses start-up edges.
    do_reset();
    idle(4);
    rd(BASE + 32'h04);
    check("t1_resp", {31'h0, resp}, 32'h1);
    check("t1_in", rdata, 32'h0000A5A5);
    rd(BASE + 32'h10);
    check("t1_status", rdata, 32'h0);
    idle(1);
    check("t1_resp_pulse", {31'h0, resp}, 32'h0);

    // Byte-enabled writes to OUT.
    wr(BASE + 32'h00, 4'b0001, 32'h1234);
    wr(BASE + 32'h00, 4'b0010, 32'h5600);
    check("t2_gpio_bo", {16'h0, gpio_out}, 32'h5634);
    rd(BASE + 32'h00);
    check("t2_out_rd", rdata, 32'h00005634);

    // Set / clear aliases.
    wr(BASE + 32'h00, 4'hF, 32'h00F0);
    wr(BASE + 32'h08, 4'hF, 32'h000F);
    check("t3_set", {16'h0, gpio_out}, 32'h00FF);
    wr(BASE + 32'h0C, 4'hF, 32'h0030);
    check("t3_clr", {16'h0, gpio_out}, 32'h00CF);
    rd(BASE + 32'h08);
    check("t3_set_rd", rdata, 32'h0);
    rd(BASE + 32'h0C);
    check("t3_clr_rd", rdata, 32'h0);

    // Edge detect, irq, W1C and same-cycle edge-vs-clear.
    wr(BASE + 32'h14, 4'hF, 32'h1);
    gpio = 16'hA5A4;
    idle(S + 3);
    wr(BASE + 32'h10, 4'hF, 32'h1);
    idle(2);
    check("t4_irq_idle", {31'h0, irq}, 32'h0);
    gpio = 16'hA5A5;
    idle(S + 1);
    check("t4_irq_lag", {31'h0, irq}, 32'h0);
    idle(1);
    check("t4_irq_rise", {31'h0, irq}, 32'h1);
    rd(BASE + 32'h10);
    check("t4_status", rdata, 32'h1);
    wr(BASE + 32'h10, 4'hF, 32'h1);
    check("t4_irq_hold", {31'h0, irq}, 32'h1);
    idle(1);
    check("t4_irq_fall", {31'h0, irq}, 32'h0);
    gpio = 16'hA5A4;
    idle(S);
    wr(BASE + 32'h10, 4'hF, 32'h1);
    rd(BASE + 32'h10);
    check("t4_set_wins", rdata, 32'h1);
    wr(BASE + 32'h10, 4'hF, 32'hFFFF);

    // INFO, misses and reserved offset.
    rd(BASE + 32'h18);
    check("t5_info", rdata, 32'h01021010);
    rd(BASE + 32'h40);
    check("t5_miss_resp", {31'h0, resp}, 32'h1);
    check("t5_miss_rd", rdata, 32'h0);
    rd(BASE + 32'h1C);
    check("t5_rsvd_resp", {31'h0, resp}, 32'h1);
    check("t5_rsvd_rd", rdata, 32'h0);
    wr(BASE + 32'h1C, 4'hF, 32'hFFFF_FFFF);
    wr(BASE + 32'h40, 4'hF, 32'hFFFF_FFFF);
    wr(BASE + 32'h8000_0014, 4'hF, 32'hFFFF_FFFF);
    check("t5_out_kept", {16'h0, gpio_out}, 32'h00CF);
    rd(BASE + 32'h14);
    check("t5_mask_kept", rdata, 32'h1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1) == 1;
      be    = 4'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 9) == 0) addr = {$urandom_range(1, 255), 5'($urandom)} << 0;
      else addr = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) gpio = 16'($urandom);
      tick();
    end
    idle(S + 2);

    // Reset arriving while a read response is on the bus.
    rd(BASE + 32'h04);
    check("t6_resp_before", {31'h0, resp}, 32'h1);
    #2;
    arst_n = 1'b0;
    #1;
    check("t6_resp_drop", {31'h0, resp}, 32'h0);
    check("t6_rdata_drop", rdata, 32'h0);
    check("t6_gpio_bo", {16'h0, gpio_out}, 32'h0);
    check("t6_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    model_reset();
    arst_n = 1'b1;
    idle(4);
    check("t6_no_resp", {31'h0, resp}, 32'h0);
    rd(BASE + 32'h10);
    check("t6_status_clr", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udm_gpio_regs.md
Name: udm_gpio_regs

Overview:
- Parametrised register-mapped GPIO slave on the UDM memory bus (udm_memsplit master side).
- Replaces hand-coded LED/SW decode in board top levels.
- Provides:
  - a byte-writable output register with atomic set/clear aliases;
  - synchronised inputs;
  - sticky edge-detect status with mask;
  - a level interrupt line.

Parameters:
- ADDR_BASE, 32'h0, byte base address; must be 32-byte aligned.
- OUT_WIDTH, 16, output port width, 1..32.
- IN_WIDTH, 16, input port width, 1..32.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  reset, asynchronous assert, active low
- bus_req_i  in  1  request valid
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_bi  in  32  byte address
- bus_be_bi  in  4  byte enables
- bus_wdata_bi  in  32  write data
- bus_ack_o  out  1  request accepted
- bus_resp_o  out  1  read data valid
- bus_rdata_bo  out  32  read data
- gpio_bi  in  IN_WIDTH  asynchronous inputs
- gpio_bo  out  OUT_WIDTH  output register
- irq_o  out  1  interrupt, registered

Behaviour:
- **Reset.** One clock domain. Reset is asynchronous and active-low (arst_n_i). While asserted, all of the following are 0:
  - gpio_bo, bus_resp_o, bus_rdata_bo, irq_o;
  - sync chain, prev-sample register, EDGE_STATUS, EDGE_MASK, arm counter.
- **Accept.** bus_ack_o = bus_req_i (combinational; always ready). A transfer occurs in any cycle with req high.
- **Decode.** Hit when bus_addr_bi[31:5] == ADDR_BASE[31:5]. Register index = bus_addr_bi[4:2]; bits [1:0] are ignored.
- **Register map** (offsets from ADDR_BASE):
  - 0x00 OUT: RW. Write honours bus_be_bi per byte.
  - 0x04 IN: RO. Synchronised input value.
  - 0x08 OUT_SET: WO. OUT |= wdata, byte-enable masked. Reads 0.
  - 0x0C OUT_CLR: WO. OUT &= ~wdata, byte-enable masked. Reads 0.
  - 0x10 EDGE_STATUS: sticky; write-1-to-clear per enabled byte.
  - 0x14 EDGE_MASK: RW, byte-enable honoured.
  - 0x18 INFO: RO = {8'h01, 8'(SYNC_STAGES), 8'(IN_WIDTH), 8'(OUT_WIDTH)}.
  - 0x1C: reserved. Reads 0, writes ignored.
- **Widths.**
  - Bits above OUT_WIDTH/IN_WIDTH are discarded on write and read as 0.
  - gpio_bo = OUT register directly (no extra stage).
- **Read.** Request in cycle N → bus_resp_o = 1 and bus_rdata_bo valid in cycle N+1, single-cycle pulse.
  - bus_rdata_bo = 0 whenever bus_resp_o = 0.
  - Miss or reserved address: still responds, with rdata 0 (bus never hangs).
- **Write.** Effect visible in the register on cycle N+1. No response is generated. Misses are ignored.
- **Synchroniser.** gpio_bi passes through a SYNC_STAGES flop chain to give the IN value. prev holds IN delayed one cycle.
- **Edge detect.** rise = IN & ~prev; fall = ~IN & prev. EDGE_STATUS |= (rise | fall) each cycle, once armed.
- **Arming.** After reset release, detection is suppressed until an arm counter reaches SYNC_STAGES+1 cycles, then stays armed. This prevents spurious edges from the zero-reset chain.
- **Simultaneous set/clear.** An edge and a W1C on the same bit in the same cycle: the set wins (bit stays 1).
- **irq_o.** Registered: irq_o <= |(EDGE_STATUS & EDGE_MASK), so it follows the register by one cycle.
- **Reset mid-read.** A pending bus_resp_o is dropped immediately; no response after release.
- **Back-to-back.** Back-to-back requests are allowed every cycle. A read following a write to the same register returns the new value.

Decomposition:
- Package udm_gpio_pkg:
  - register offset localparams (REG_OUT … REG_INFO);
  - INFO version constant 8'h01;
  - a byte-enable-mask function, be → 32-bit mask.
- One sub-module: udm_gpio_sync. It contains:
  - per-bit flop chain (parameter WIDTH, STAGES);
  - prev register;
  - arm counter.
  
  Outputs: sync value, rise, fall, armed.

Test Plan:
- Reset, then read 0x04 with gpio_bi=16'hA5A5 held → resp 1 cycle after req, rdata 32'h0000A5A5, EDGE_STATUS reads 0 (arming suppressed).
- Write OUT=32'h1234 with be=4'b0001, then be=4'b0010 with 32'h5600 → gpio_bo = 16'h5634; read 0x00 → 32'h00005634.
- OUT=16'h00F0 → write SET 32'h000F, then CLR 32'h0030 → gpio_bo 16'h00FF then 16'h00CF; reads of 0x08 and 0x0C → 0.
- EDGE_MASK=1, toggle gpio_bi[0] 0→1 → EDGE_STATUS[0]=1 after SYNC_STAGES+1 cycles, irq_o=1 one cycle later. Write 1 to 0x10 → irq_o falls. Repeat with W1C in the same cycle as a new edge → bit stays 1.
- Read 0x18 with defaults → 32'h01021010. Read ADDR_BASE+0x40 and 0x1C → resp pulse, rdata 0. Writes there leave all registers unchanged.
- Assert arst_n_i in the cycle after a read request → bus_resp_o 0 immediately, all outputs 0, no response after release.
